// File: rtl/fm_pool_src_buffer_if.sv
// Producer/consumer bus for fm_pool_src_buffer.
// master: producer + pool stage side, slave: the buffer.
interface fm_pool_src_buffer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
);
   logic              wr_begin;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              frame_release;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              fm_ready;
   logic              fm_write_complete;
   logic              wr_drop;

   modport master (
      output wr_begin, wr_en, wr_data, frame_release, rd_en, rd_addr,
      input  rd_data, fm_ready, fm_write_complete, wr_drop
   );

   modport slave (
      input  wr_begin, wr_en, wr_data, frame_release, rd_en, rd_addr,
      output rd_data, fm_ready, fm_write_complete, wr_drop
   );
endinterface

// File: rtl/fm_pool_src_buffer.sv
// Feature-map buffer between a conv output stream and the 2x2 pool stage.
// Stores one ROW_LEN x ROWS map written in raster order, serves reads with
// 2-cycle latency, and flags row-pair / frame availability.
// Optional macro FM_BUF_RW_FWD_EN: a read of the address being written in
// the same cycle returns the new pixel instead of the old contents.
module fm_pool_src_buffer #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 7,
   parameter int ROW_LEN = 8,
   parameter int ROWS    = 8
) (
   input logic               clk,
   input logic               rst,
   fm_pool_src_buffer_if.slave bus
);
   localparam int DEPTH = ROW_LEN * ROWS;
   localparam int AW    = $clog2(DEPTH);
   localparam int RB    = $clog2(ROW_LEN);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t            state, nxt_state;
   logic [ADDR_W-1:0] wr_ptr, nxt_ptr;
   logic              wr_do;
   logic [AW-1:0]     wr_idx;
   logic              drop;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W:0]   row_ix, need;
   logic              in_range;
   logic [DATA_W-1:0] rd_word, data_q;
   logic              rd_vld_q;

   // Write/next-state decode; wr_begin always restarts the frame at addr 0
   always_comb begin
      nxt_state = state;
      nxt_ptr   = wr_ptr;
      wr_do     = 1'b0;
      wr_idx    = '0;
      drop      = 1'b0;
      if (bus.wr_begin) begin
         nxt_state = FILL;
         wr_do     = bus.wr_en;
         nxt_ptr   = bus.wr_en ? ADDR_W'(1) : '0;
      end else begin
         case (state)
            IDLE: drop = bus.wr_en;
            FILL: if (bus.wr_en) begin
               wr_do   = 1'b1;
               wr_idx  = wr_ptr[AW-1:0];
               nxt_ptr = wr_ptr + ADDR_W'(1);
               if (wr_ptr == ADDR_W'(DEPTH - 1)) nxt_state = FULL;
            end
            FULL: begin
               drop = bus.wr_en;
               if (bus.frame_release) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
         endcase
      end
   end

   // Pixel count needed before the row pair holding rd_addr is complete
   always_comb begin
      row_ix = (ADDR_W+1)'(bus.rd_addr >> RB);
      need   = ((row_ix | (ADDR_W+1)'(1)) + (ADDR_W+1)'(1)) << RB;
   end

   // FSM state, write pointer and registered handshakes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                 <= IDLE;
         wr_ptr                <= '0;
         bus.fm_ready          <= 1'b0;
         bus.fm_write_complete <= 1'b0;
         bus.wr_drop           <= 1'b0;
      end else begin
         state  <= nxt_state;
         wr_ptr <= nxt_ptr;
         case (nxt_state)
            FILL:    bus.fm_ready <= ({1'b0, nxt_ptr} >= need);
            FULL:    bus.fm_ready <= 1'b1;
            default: bus.fm_ready <= 1'b0;
         endcase
         bus.fm_write_complete <= (nxt_state == FULL);
         if (drop) bus.wr_drop <= 1'b1;
      end
   end

   // Pixel storage, contents deliberately not reset
   always_ff @(posedge clk) begin
      if (wr_do) mem[wr_idx] <= bus.wr_data;
   end

   // Stage-1 read word; array read happens before this cycle's write lands
   always_comb begin
      in_range = (int'(bus.rd_addr) < DEPTH);
      rd_word  = '0;
      if (in_range) rd_word = mem[bus.rd_addr[AW-1:0]];
`ifdef FM_BUF_RW_FWD_EN
      if (in_range && wr_do && (wr_idx == bus.rd_addr[AW-1:0]))
         rd_word = bus.wr_data;
`endif
   end

   // Two-stage read pipeline; rd_data holds when no read is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q      <= '0;
         rd_vld_q    <= 1'b0;
         bus.rd_data <= '0;
      end else begin
         rd_vld_q <= bus.rd_en;
         if (bus.rd_en) data_q <= rd_word;
         if (rd_vld_q) bus.rd_data <= data_q;
      end
   end
endmodule

// File: tb/tb_fm_pool_src_buffer.sv
// Directed bench for fm_pool_src_buffer.
module tb_fm_pool_src_buffer;
   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   fm_pool_src_buffer_if bus ();

   fm_pool_src_buffer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_px(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_begin = 0; bus.wr_en = 0; bus.wr_data = 0;
      bus.frame_release = 0; bus.rd_en = 0; bus.rd_addr = 0;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.fm_ready); end
      checks++; if (bus.fm_write_complete !== 1'b0) begin errors++; $display("FAIL reset_complete got=%b exp=0", bus.fm_write_complete); end
      checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", bus.wr_drop); end
   endtask

   // 64 writes of addr+1; rd_addr 0 / 17 / 63 over the three phases
   task automatic test_fill();
      bus.wr_begin = 1'b1; tick(); bus.wr_begin = 1'b0;
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL fill_begin_ready got=%b exp=0", bus.fm_ready); end
      for (int k = 1; k <= 64; k++) begin
         logic exp_rdy;
         bus.rd_addr = (k <= 16) ? 7'd0 : (k <= 32) ? 7'd17 : 7'd63;
         wr_px(8'(k));
         exp_rdy = (k <= 16) ? (k >= 16) : (k <= 32) ? (k >= 32) : (k >= 64);
         checks++; if (bus.fm_ready !== exp_rdy) begin errors++; $display("FAIL fill_ready k=%0d got=%b exp=%b", k, bus.fm_ready, exp_rdy); end
         checks++; if (bus.fm_write_complete !== (k == 64)) begin errors++; $display("FAIL fill_complete k=%0d got=%b exp=%b", k, bus.fm_write_complete, (k == 64)); end
      end
      checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL fill_drop got=%b exp=0", bus.wr_drop); end
   endtask

   task automatic test_read_full();
      bus.rd_en = 1'b1; bus.rd_addr = 7'd0;  tick();
      bus.rd_addr = 7'd9;  tick();
      checks++; if (bus.rd_data !== 8'd1) begin errors++; $display("FAIL rd_addr0 got=%h exp=01", bus.rd_data); end
      bus.rd_addr = 7'd63; tick();
      checks++; if (bus.rd_data !== 8'd10) begin errors++; $display("FAIL rd_addr9 got=%h exp=0a", bus.rd_data); end
      bus.rd_en = 1'b0; tick();
      checks++; if (bus.rd_data !== 8'd64) begin errors++; $display("FAIL rd_addr63 got=%h exp=40", bus.rd_data); end
      tick();
      checks++; if (bus.rd_data !== 8'd64) begin errors++; $display("FAIL rd_hold got=%h exp=40", bus.rd_data); end
      bus.rd_en = 1'b1; bus.rd_addr = 7'd100; tick();
      bus.rd_en = 1'b0; tick();
      checks++; if (bus.rd_data !== 8'd0) begin errors++; $display("FAIL rd_oob got=%h exp=00", bus.rd_data); end
      checks++; if (bus.fm_ready !== 1'b1) begin errors++; $display("FAIL full_ready got=%b exp=1", bus.fm_ready); end
   endtask

   task automatic test_release_drop();
      bus.frame_release = 1'b1; tick(); bus.frame_release = 1'b0;
      checks++; if (bus.fm_write_complete !== 1'b0) begin errors++; $display("FAIL rel_complete got=%b exp=0", bus.fm_write_complete); end
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL rel_ready got=%b exp=0", bus.fm_ready); end
      wr_px(8'hEE);
      checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_set got=%b exp=1", bus.wr_drop); end
      bus.rd_en = 1'b1; bus.rd_addr = 7'd0; tick();
      bus.rd_en = 1'b0; tick();
      checks++; if (bus.rd_data !== 8'd1) begin errors++; $display("FAIL drop_mem got=%h exp=01", bus.rd_data); end
   endtask

   // Abort after 30 writes, then a full new frame of addr+2
   task automatic test_abort();
      bus.rd_addr = 7'd0;
      bus.wr_begin = 1'b1; tick(); bus.wr_begin = 1'b0;
      for (int k = 1; k <= 30; k++) wr_px(8'hC0);
      checks++; if (bus.fm_ready !== 1'b1) begin errors++; $display("FAIL abort_pre_ready got=%b exp=1", bus.fm_ready); end
      bus.wr_begin = 1'b1; tick(); bus.wr_begin = 1'b0;
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b exp=0", bus.fm_ready); end
      for (int k = 1; k <= 64; k++) begin
         wr_px(8'(k + 1));
         checks++; if (bus.fm_write_complete !== (k == 64)) begin errors++; $display("FAIL abort_complete k=%0d got=%b exp=%b", k, bus.fm_write_complete, (k == 64)); end
      end
      bus.rd_en = 1'b1; bus.rd_addr = 7'd9; tick();
      bus.rd_en = 1'b0; tick();
      checks++; if (bus.rd_data !== 8'd11) begin errors++; $display("FAIL abort_rd9 got=%h exp=0b", bus.rd_data); end
   endtask

   // Same-cycle write/read of addr 5, then async reset mid-fill
   task automatic test_rw_and_async_reset();
      logic [7:0] exp_rw;
      bus.wr_begin = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h11; tick();
      bus.wr_begin = 1'b0; bus.wr_en = 1'b0;
      checks++; if (bus.fm_write_complete !== 1'b0) begin errors++; $display("FAIL restart_complete got=%b exp=0", bus.fm_write_complete); end
      wr_px(8'h22); wr_px(8'h33); wr_px(8'h44); wr_px(8'h55);
      bus.wr_en = 1'b1; bus.wr_data = 8'hA5; bus.rd_en = 1'b1; bus.rd_addr = 7'd5; tick();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; tick();
`ifdef FM_BUF_RW_FWD_EN
      exp_rw = 8'hA5;
`else
      exp_rw = 8'h07;
`endif
      checks++; if (bus.rd_data !== exp_rw) begin errors++; $display("FAIL rw_same got=%h exp=%h", bus.rd_data, exp_rw); end
      bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0; bus.rd_addr = 7'd0; tick();
      checks++; if (bus.rd_data !== 8'hA5) begin errors++; $display("FAIL rw_after got=%h exp=a5", bus.rd_data); end
      bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0; tick();
      checks++; if (bus.rd_data !== 8'h11) begin errors++; $display("FAIL begin_wr_addr0 got=%h exp=11", bus.rd_data); end
      for (int k = 7; k <= 20; k++) wr_px(8'(k));
      checks++; if (bus.fm_ready !== 1'b1) begin errors++; $display("FAIL pre_rst_ready got=%b exp=1", bus.fm_ready); end
      checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", bus.wr_drop); end
      #2 rst = 1'b1;
      #1;
      checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd_data got=%h exp=00", bus.rd_data); end
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", bus.fm_ready); end
      checks++; if (bus.fm_write_complete !== 1'b0) begin errors++; $display("FAIL arst_complete got=%b exp=0", bus.fm_write_complete); end
      checks++; if (bus.wr_drop !== 1'b0) begin errors++; $display("FAIL arst_drop got=%b exp=0", bus.wr_drop); end
      tick(); rst = 1'b0; tick();
      wr_px(8'h99);
      checks++; if (bus.wr_drop !== 1'b1) begin errors++; $display("FAIL idle_drop got=%b exp=1", bus.wr_drop); end
      checks++; if (bus.fm_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", bus.fm_ready); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_read_full();
      test_release_drop();
      test_abort();
      test_rw_and_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
